// File: rtl/stopwatch_timer_lap.sv
// Stopwatch / countdown timer with tick prescaler, countdown expiry and lap capture.
// Define STOPWATCH_LAP_EN to build the lap FIFO; otherwise the lap ports are tied off.
module stopwatch_timer_lap #(
    parameter int WIDTH     = 16,
    parameter int PRESCALE  = 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             lap,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             tc,
    output logic [WIDTH-1:0] lap_data,
    output logic             lap_valid,
    input  logic             lap_ready,
    output logic             lap_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_EXPIRED} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic             r_mode, w_mode_nxt;
    logic             r_tc, w_tc_nxt;
    logic             w_pre_hit, w_pre_clr, w_pre_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_mode  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_mode  <= w_mode_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    // Priority clear > stop > start is encoded by the nesting below.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode;
        w_tc_nxt    = 1'b0;
        w_pre_clr   = 1'b0;
        w_pre_adv   = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
            w_pre_clr   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_mode_nxt = mode;
                        w_pre_clr  = 1'b1;
                        if (mode && load_val == '0) begin
                            w_state_nxt = S_EXPIRED;
                            w_count_nxt = '0;
                            w_tc_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = S_RUNNING;
                            w_count_nxt = mode ? load_val : '0;
                        end
                    end
                end
                S_RUNNING: begin
                    if (stop) begin
                        w_state_nxt = S_PAUSED;
                    end else begin
                        w_pre_adv = 1'b1;
                        if (w_pre_hit) begin
                            if (r_mode) begin
                                w_count_nxt = r_count - 1'b1;
                                if (r_count == WIDTH'(1)) begin
                                    w_state_nxt = S_EXPIRED;
                                    w_tc_nxt    = 1'b1;
                                end
                            end else begin
                                w_count_nxt = r_count + 1'b1;
                                w_tc_nxt    = (r_count == '1);
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (start) w_state_nxt = S_RUNNING;
                end
                S_EXPIRED: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int PW = $clog2(PRESCALE + 1);
            logic [PW-1:0] r_pre;
            assign w_pre_hit = (r_pre == PW'(PRESCALE - 1));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         r_pre <= '0;
                else if (w_pre_clr) r_pre <= '0;
                else if (w_pre_adv) r_pre <= w_pre_hit ? '0 : r_pre + 1'b1;
            end
        end else begin : g_nopre
            logic w_unused_pre;
            assign w_unused_pre = w_pre_clr | w_pre_adv;
            assign w_pre_hit    = 1'b1;
        end
    endgenerate

    assign count   = r_count;
    assign running = (r_state == S_RUNNING);
    assign expired = (r_state == S_EXPIRED);
    assign tc      = r_tc;

`ifdef STOPWATCH_LAP_EN
    localparam int AW = $clog2(LAP_DEPTH);

    logic [WIDTH-1:0] r_mem [LAP_DEPTH];
    logic [AW:0]      r_wptr, r_rptr;
    logic             r_ovf;
    logic             w_empty, w_full, w_pop, w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && lap_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the lap.
    assign w_push  = lap && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= r_count;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (lap && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    assign lap_data     = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign lap_valid    = !w_empty;
    assign lap_overflow = r_ovf;
`else
    logic w_unused_lap;
    assign w_unused_lap = &{1'b0, lap, lap_ready, (LAP_DEPTH > 1)};
    assign lap_data     = '0;
    assign lap_valid    = 1'b0;
    assign lap_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer_lap.sv
// Directed bench for stopwatch_timer_lap: a vector table on a PRESCALE=1 16-bit
// instance, plus hand sequences for wrap (WIDTH=4), prescaled countdown, laps and reset.
module tb_stopwatch_timer_lap;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        start, stop, clear, mode, lap, lap_ready;
    logic [15:0] load_val;

    logic [15:0] cnt_a, ld_a;
    logic        run_a, exp_a, tc_a, lv_a, ovf_a;
    logic [3:0]  cnt_b, ld_b;
    logic        run_b, exp_b, tc_b, lv_b, ovf_b;
    logic [7:0]  cnt_c, ld_c;
    logic        run_c, exp_c, tc_c, lv_c, ovf_c;

    int checks = 0;
    int failures = 0;

    stopwatch_timer_lap #(.WIDTH(16), .PRESCALE(1), .LAP_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .mode(mode),
        .load_val(load_val), .lap(lap), .count(cnt_a), .running(run_a), .expired(exp_a),
        .tc(tc_a), .lap_data(ld_a), .lap_valid(lv_a), .lap_ready(lap_ready), .lap_overflow(ovf_a));

    stopwatch_timer_lap #(.WIDTH(4), .PRESCALE(1), .LAP_DEPTH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .mode(mode),
        .load_val(load_val[3:0]), .lap(lap), .count(cnt_b), .running(run_b), .expired(exp_b),
        .tc(tc_b), .lap_data(ld_b), .lap_valid(lv_b), .lap_ready(lap_ready), .lap_overflow(ovf_b));

    stopwatch_timer_lap #(.WIDTH(8), .PRESCALE(3), .LAP_DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .mode(mode),
        .load_val(load_val[7:0]), .lap(lap), .count(cnt_c), .running(run_c), .expired(exp_c),
        .tc(tc_c), .lap_data(ld_c), .lap_valid(lv_c), .lap_ready(lap_ready), .lap_overflow(ovf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, sp, cl, md;
        logic [15:0] ld;
        logic [15:0] ecnt;
        logic        erun, eexp, etc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic st, sp, cl, md, input logic [15:0] ld,
                                input logic [15:0] ecnt, input logic erun, eexp, etc);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.md = md; v.ld = ld;
        v.ecnt = ecnt; v.erun = erun; v.eexp = eexp; v.etc = etc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clear = 0; mode = 0; lap = 0; lap_ready = 0; load_val = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
    endtask

    int          ntc;
    logic [15:0] laps [4];

    initial begin
        // ---- vector table (instance a: WIDTH 16, PRESCALE 1) ----
        add(0,0,0,0,0,  0,0,0,0);
        add(1,0,0,0,0,  0,1,0,0);
        for (int i = 1; i <= 10; i++) add(0,0,0,0,0, 16'(i),1,0,0);
        add(0,1,0,0,0, 10,0,0,0);
        repeat (4) add(0,0,0,0,0, 10,0,0,0);
        add(1,0,0,0,0, 10,1,0,0);
        add(0,0,0,0,0, 11,1,0,0);
        add(1,1,0,0,0, 11,0,0,0);   // both in RUNNING: pause
        add(1,1,0,0,0, 11,1,0,0);   // both in PAUSED: resume
        add(0,0,0,0,0, 12,1,0,0);
        add(0,0,1,0,0,  0,0,0,0);
        add(0,1,0,0,0,  0,0,0,0);   // stop in IDLE is a no-op
        add(1,1,0,0,0,  0,1,0,0);   // both in IDLE: start
        add(0,0,0,0,0,  1,1,0,0);
        add(0,0,1,0,0,  0,0,0,0);
        add(1,0,0,0,0,  0,1,0,0);   // mode latched only at start
        add(0,0,0,1,0,  1,1,0,0);
        add(0,0,0,1,0,  2,1,0,0);
        add(0,0,1,0,0,  0,0,0,0);
        add(1,0,0,1,3,  3,1,0,0);   // countdown from 3
        add(0,0,0,0,0,  2,1,0,0);
        add(0,0,0,0,0,  1,1,0,0);
        add(0,0,0,0,0,  0,0,1,1);
        add(0,0,0,0,0,  0,0,1,0);
        add(1,0,0,0,0,  0,0,1,0);   // start ignored in EXPIRED
        add(0,1,0,0,0,  0,0,1,0);
        add(0,0,1,0,0,  0,0,0,0);
        add(1,0,0,1,0,  0,0,1,1);   // load 0: straight to EXPIRED
        add(0,0,0,0,0,  0,0,1,0);
        add(0,0,1,0,0,  0,0,0,0);

        idle_inputs();
        rst_n = 0;
        repeat (2) step();
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_running", 32'(run_a), 0);
        chk("rst_expired", 32'(exp_a), 0);
        chk("rst_tc", 32'(tc_a), 0);
        chk("rst_lap_valid", 32'(lv_a), 0);
        chk("rst_lap_data", 32'(ld_a), 0);
        chk("rst_lap_ovf", 32'(ovf_a), 0);
        rst_n = 1;

        foreach (tbl[i]) begin
            start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl;
            mode = tbl[i].md; load_val = tbl[i].ld;
            step();
            chk($sformatf("vec%0d_count", i), 32'(cnt_a), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d_running", i), 32'(run_a), 32'(tbl[i].erun));
            chk($sformatf("vec%0d_expired", i), 32'(exp_a), 32'(tbl[i].eexp));
            chk($sformatf("vec%0d_tc", i), 32'(tc_a), 32'(tbl[i].etc));
        end
        idle_inputs();

        // ---- WIDTH=4 wrap on instance b ----
        do_clear();
        start = 1; step(); start = 0;
        ntc = 0;
        for (int i = 1; i <= 17; i++) begin
            step();
            ntc += int'(tc_b);
            chk($sformatf("wrap%0d_count", i), 32'(cnt_b), 32'(i % 16));
            chk($sformatf("wrap%0d_tc", i), 32'(tc_b), 32'(i == 16));
            chk($sformatf("wrap%0d_running", i), 32'(run_b), 1);
        end
        chk("wrap_tc_pulses", 32'(ntc), 1);

        // ---- prescaled countdown on instance c ----
        do_clear();
        start = 1; mode = 1; load_val = 16'd5; step(); idle_inputs();
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("down%0d_count", i), 32'(cnt_c), (i < 15) ? 32'(5 - i / 3) : 0);
            chk($sformatf("down%0d_expired", i), 32'(exp_c), 32'(i == 15));
            chk($sformatf("down%0d_tc", i), 32'(tc_c), 32'(i == 15));
        end
        step();
        chk("down_tc_drop", 32'(tc_c), 0);
        chk("down_hold_expired", 32'(exp_c), 1);
        start = 1; step(); start = 0;
        chk("down_start_ignored_exp", 32'(exp_c), 1);
        chk("down_start_ignored_run", 32'(run_c), 0);
        chk("down_start_ignored_cnt", 32'(cnt_c), 0);
        do_clear();
        chk("down_clear_exp", 32'(exp_c), 0);
        chk("down_clear_cnt", 32'(cnt_c), 0);
        chk("down_clear_run", 32'(run_c), 0);

        // ---- laps 3,6,9,12,15 into a 4-deep FIFO (instance a) ----
        do_clear();
        start = 1; step(); start = 0;
        for (int n = 0; n <= 15; n++) begin
            lap = (n > 0) && (n % 3 == 0);
            step();
        end
        lap = 0; stop = 1; step(); stop = 0;
        laps[0] = 3; laps[1] = 6; laps[2] = 9; laps[3] = 12;
        chk("lap_overflow", 32'(ovf_a), 32'(LAP_EN));
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("lap%0d_valid", j), 32'(lv_a), 32'(LAP_EN));
            chk($sformatf("lap%0d_data", j), 32'(ld_a), LAP_EN ? 32'(laps[j]) : 0);
            lap_ready = 1; step(); lap_ready = 0;
        end
        chk("lap_drained", 32'(lv_a), 0);

        // ---- clear+stop+start while running at count 7 ----
        do_clear();
        start = 1; step(); start = 0;
        for (int n = 0; n < 7; n++) begin
            lap = 1; step();
        end
        lap = 0;
        chk("cls_pre_count", 32'(cnt_a), 7);
        chk("cls_pre_ovf", 32'(ovf_a), 32'(LAP_EN));
        clear = 1; stop = 1; start = 1; step(); idle_inputs();
        chk("cls_running", 32'(run_a), 0);
        chk("cls_count", 32'(cnt_a), 0);
        chk("cls_lap_valid", 32'(lv_a), 0);
        chk("cls_ovf", 32'(ovf_a), 0);
        step();
        chk("cls_stays_idle", 32'(run_a), 0);
        chk("cls_stays_zero", 32'(cnt_a), 0);

        // ---- asynchronous reset mid-run at count 20 ----
        do_clear();
        start = 1; step(); start = 0;
        for (int n = 0; n < 20; n++) begin
            lap = (n == 5); step();
        end
        lap = 0;
        chk("arst_pre_count", 32'(cnt_a), 20);
        chk("arst_pre_lap_valid", 32'(lv_a), 32'(LAP_EN));
        #2 rst_n = 0;
        #1;
        chk("arst_count", 32'(cnt_a), 0);
        chk("arst_running", 32'(run_a), 0);
        chk("arst_expired", 32'(exp_a), 0);
        chk("arst_tc", 32'(tc_a), 0);
        chk("arst_lap_valid", 32'(lv_a), 0);
        chk("arst_lap_data", 32'(ld_a), 0);
        chk("arst_lap_ovf", 32'(ovf_a), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) step();
        chk("arst_idle_run", 32'(run_a), 0);
        chk("arst_idle_count", 32'(cnt_a), 0);
        start = 1; step(); start = 0;
        step();
        chk("arst_restart_run", 32'(run_a), 1);
        chk("arst_restart_count", 32'(cnt_a), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_timer_lap.md
# stopwatch_timer_lap

Parametrised stopwatch/countdown timer: the next generation of the 16-bit start/stop stopwatch. It adds configurable width, a tick prescaler, up/down mode with countdown expiry, a synchronous clear, and a lap-capture FIFO with a valid/ready drain port. It sits beside the CPU-facing register block: control pulses come in from the register block, and lap values are drained by the same interface.

## Interface
- WIDTH, 16: counter width in bits (≥ 4)
- PRESCALE, 1: enabled clock cycles per count step (≥ 1)
- LAP_DEPTH, 4: lap FIFO entries (power of two, ≥ 2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; start from IDLE or resume from PAUSED
- stop  in  1  single-cycle pulse; pause while RUNNING
- clear  in  1  synchronous; forces IDLE, reloads count, empties lap FIFO, clears sticky flags
- mode  in  1  0 = count up, 1 = count down; sampled only on start from IDLE
- load_val  in  WIDTH  countdown start value; sampled on start from IDLE in down mode
- lap  in  1  single-cycle pulse; capture current count
- count  out  WIDTH  current count
- running  out  1  high in RUNNING
- expired  out  1  high in EXPIRED (down mode reached 0)
- tc  out  1  one-cycle pulse on up-mode wrap or down-mode expiry
- lap_data  out  WIDTH  FIFO head (first-word fall-through)
- lap_valid  out  1  FIFO non-empty
- lap_ready  in  1  pop head when lap_valid && lap_ready
- lap_overflow  out  1  sticky; a lap was dropped because the FIFO was full

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED. Reset enters IDLE.
- IDLE --start--> RUNNING: latch mode; count ← 0 (up) or load_val (down); prescaler ← 0.
  - Down mode with load_val = 0: go directly to EXPIRED and pulse tc.
- RUNNING --stop--> PAUSED: count and prescaler hold. PAUSED --start--> RUNNING, with the prescaler resuming from its held value.
- RUNNING, down mode, count steps 1→0: go to EXPIRED, pulse tc, count holds 0. Only clear leaves EXPIRED; start and stop are ignored there.
- RUNNING, up mode, count at 2^WIDTH−1: the next step wraps to 0, tc pulses, and counting continues.
- Priority within one cycle: clear > stop > start. If start and stop arrive together in RUNNING, the block pauses. If they arrive together in PAUSED or IDLE, it starts.
- In IDLE, start ignores the stop pulse; stop in IDLE is a no-op.
- Lap: valid in any state. It pushes the count as seen before that edge's update.
  - Full FIFO with no pop in that cycle: the entry is dropped and lap_overflow is set.
  - Full FIFO with a pop in the same cycle: the push is accepted.
- clear wins over a lap or pop in the same cycle.

## Timing
- Reset values: count 0, running 0, expired 0, tc 0, lap_valid 0, lap_data 0, lap_overflow 0, state IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- start sampled at edge k: running = 1 after edge k. Count steps occur at edges k+PRESCALE, k+2·PRESCALE, and so on.
- stop sampled at edge j: running = 0 after edge j. A step due at edge j is suppressed.
- tc is high for exactly the cycle following the wrapping or expiring edge.
- Lap capture at edge m: lap_valid = 1 after edge m if the FIFO was empty. Pop at edge p exposes the next entry after edge p.
- Width: count arithmetic is modulo 2^WIDTH. The prescaler is ceil(log2(PRESCALE+1)) bits, and there is no prescaler logic when PRESCALE = 1.

## Configuration
- STOPWATCH_LAP_EN
  - Defined: the lap FIFO and its ports behave as above.
  - Undefined: no FIFO storage is instantiated. lap and lap_ready are ignored, and lap_data, lap_valid and lap_overflow are tied to 0. Ports remain present.

## Test plan
- Reset, then start in up mode with PRESCALE=1; count is 10 exactly 10 cycles after the start edge. stop for 5 cycles holds 10; start resumes to 11 one cycle later.
- WIDTH=4: run up 16 steps; count wraps 15→0, tc pulses once, and running stays 1.
- Down mode with load_val=5 and PRESCALE=3: expired and tc rise 15 cycles after start, count=0. start then has no effect; clear returns to IDLE with count 0.
- LAP_DEPTH=4: five laps at counts 3, 6, 9, 12, 15 with lap_ready=0. The FIFO holds 3, 6, 9, 12 and lap_overflow=1. Drain yields 3, 6, 9, 12, then lap_valid=0.
- Same cycle clear+stop+start while RUNNING at count 7: IDLE, count 0, FIFO emptied, and lap_overflow cleared on the next cycle.
- Assert rst_n low mid-run at count 20: all outputs go to 0 immediately without a clock edge. After release, the block stays in IDLE until start.
